// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: shared definitions for the MIPS32 execute stage.
// Holds the ALU selector/operation codes, common word constants,
// the divider state encodings and a small helper to recognise divides.
package ex_stage_pkg;

    localparam int DIV_CYCLES = 32;

    typedef logic [2:0]  aluSel_t;
    typedef logic [7:0]  aluOp_t;
    typedef logic [4:0]  regAddr_t;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } hiLo_t;

    localparam logic [31:0] Zero_Word     = 32'h0000_0000;
    localparam logic        Write_Enable  = 1'b1;
    localparam logic        Write_Disable = 1'b0;
    localparam logic        Stop          = 1'b1;
    localparam logic        NoStop        = 1'b0;

    // Result classes
    localparam aluSel_t EXE_RES_NOP         = 3'b000;
    localparam aluSel_t EXE_RES_LOGIC       = 3'b001;
    localparam aluSel_t EXE_RES_SHIFT       = 3'b010;
    localparam aluSel_t EXE_RES_MOVE        = 3'b011;
    localparam aluSel_t EXE_RES_ARITHMETIC  = 3'b100;
    localparam aluSel_t EXE_RES_JUMP_BRANCH = 3'b110;

    // Operation codes (LUI arrives from decode as OR with a pre-shifted immediate)
    localparam aluOp_t EXE_NOP_OP  = 8'b0000_0000;
    localparam aluOp_t EXE_AND_OP  = 8'b0010_0100;
    localparam aluOp_t EXE_OR_OP   = 8'b0010_0101;
    localparam aluOp_t EXE_XOR_OP  = 8'b0010_0110;
    localparam aluOp_t EXE_NOR_OP  = 8'b0010_0111;
    localparam aluOp_t EXE_SLL_OP  = 8'b0111_1100;
    localparam aluOp_t EXE_SRL_OP  = 8'b0000_0010;
    localparam aluOp_t EXE_SRA_OP  = 8'b0000_0011;
    localparam aluOp_t EXE_SLT_OP  = 8'b0010_1010;
    localparam aluOp_t EXE_SLTU_OP = 8'b0010_1011;
    localparam aluOp_t EXE_ADD_OP  = 8'b0010_0000;
    localparam aluOp_t EXE_ADDU_OP = 8'b0010_0001;
    localparam aluOp_t EXE_SUB_OP  = 8'b0010_0010;
    localparam aluOp_t EXE_SUBU_OP = 8'b0010_0011;
    localparam aluOp_t EXE_MFHI_OP = 8'b0001_0000;
    localparam aluOp_t EXE_MTHI_OP = 8'b0001_0001;
    localparam aluOp_t EXE_MFLO_OP = 8'b0001_0010;
    localparam aluOp_t EXE_MTLO_OP = 8'b0001_0011;
    localparam aluOp_t EXE_DIV_OP  = 8'b0001_1010;
    localparam aluOp_t EXE_DIVU_OP = 8'b0001_1011;

    // Divider FSM states
    localparam logic [1:0] DivFree   = 2'b00;
    localparam logic [1:0] DivByZero = 2'b01;
    localparam logic [1:0] DivOn     = 2'b10;
    localparam logic [1:0] DivEnd    = 2'b11;

    function automatic logic isDivOp(input aluOp_t op);
        return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ex_stage_if: ID/EX operand bundle in, EX/MEM write bundle out.
// master: the pipeline side driving the ID/EX bundle and observing results.
// slave : the execute stage consuming the bundle and producing results.
interface ex_stage_if;
    import ex_stage_pkg::*;

    aluSel_t     alusel_i;
    aluOp_t      aluop_i;
    logic [31:0] reg1_i;
    logic [31:0] reg2_i;
    regAddr_t    wd_i;
    logic        wreg_i;
    logic [31:0] link_addr_i;
    logic        is_in_delayslot_i;
    logic [31:0] inst_i;

    regAddr_t    wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        whilo_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        stallreq_o;
    aluOp_t      aluop_o;
    logic        is_in_delayslot_o;
    logic [31:0] inst_o;

    modport master (
        output alusel_i, aluop_i, reg1_i, reg2_i, wd_i, wreg_i,
               link_addr_i, is_in_delayslot_i, inst_i,
        input  wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o,
               aluop_o, is_in_delayslot_o, inst_o
    );

    modport slave (
        input  alusel_i, aluop_i, reg1_i, reg2_i, wd_i, wreg_i,
               link_addr_i, is_in_delayslot_i, inst_i,
        output wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o,
               aluop_o, is_in_delayslot_o, inst_o
    );

endinterface

// File: rtl/ex_div.sv
// ex_div: iterative radix-2 restoring divider for DIV/DIVU.
// Ports: clk/rst (async active-low), start_i, signed_i, opdata1_i (dividend),
// opdata2_i (divisor), result_o = {remainder, quotient}, ready_o.
// Operands are latched when a divide begins; one quotient bit per cycle.
module ex_div
    import ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    logic [1:0]  state_q, state_d;
    logic [64:0] dividend_q, dividend_d;
    logic [31:0] divisor_q, divisor_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        negQuot_q, negQuot_d;
    logic        negRem_q, negRem_d;
    logic [31:0] absOp1, absOp2;
    logic [32:0] trialDiff;
    logic [31:0] quotFix, remFix;

    // Work on magnitudes; signs are restored once the divide finishes.
    always_comb begin
        absOp1 = (signed_i && opdata1_i[31]) ? -opdata1_i : opdata1_i;
        absOp2 = (signed_i && opdata2_i[31]) ? -opdata2_i : opdata2_i;
    end

    // Bit 32 set means the partial remainder is smaller than the divisor.
    assign trialDiff = {1'b0, dividend_q[63:32]} - {1'b0, divisor_q};

    // FSM and shift-subtract datapath; quotient bits shift in at bit 0,
    // the remainder ends up in bits 64:33.
    always_comb begin
        state_d    = state_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        cnt_d      = cnt_q;
        negQuot_d  = negQuot_q;
        negRem_d   = negRem_q;
        case (state_q)
            DivFree: begin
                if (start_i) begin
                    if (opdata2_i == Zero_Word) begin
                        state_d = DivByZero;
                    end else begin
                        state_d    = DivOn;
                        cnt_d      = 6'd0;
                        dividend_d = {32'h0, absOp1, 1'b0};
                        divisor_d  = absOp2;
                        negQuot_d  = signed_i && (opdata1_i[31] ^ opdata2_i[31]);
                        negRem_d   = signed_i && opdata1_i[31];
                    end
                end
            end
            DivByZero: begin
                state_d    = DivEnd;
                dividend_d = '0;
                negQuot_d  = 1'b0;
                negRem_d   = 1'b0;
            end
            DivOn: begin
                if (trialDiff[32]) begin
                    dividend_d = {dividend_q[63:0], 1'b0};
                end else begin
                    dividend_d = {trialDiff[31:0], dividend_q[31:0], 1'b1};
                end
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'(DIV_CYCLES - 1)) begin
                    state_d = DivEnd;
                end
            end
            DivEnd: begin
                if (!start_i) begin
                    state_d = DivFree;
                end
            end
            default: state_d = DivFree;
        endcase
    end

    // State registers; reset abandons any divide in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= DivFree;
            dividend_q <= '0;
            divisor_q  <= '0;
            cnt_q      <= '0;
            negQuot_q  <= 1'b0;
            negRem_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            cnt_q      <= cnt_d;
            negQuot_q  <= negQuot_d;
            negRem_q   <= negRem_d;
        end
    end

    // Sign correction: quotient negative on differing signs,
    // remainder follows the dividend.
    always_comb begin
        quotFix  = negQuot_q ? -dividend_q[31:0] : dividend_q[31:0];
        remFix   = negRem_q ? -dividend_q[64:33] : dividend_q[64:33];
        ready_o  = (state_q == DivEnd);
        result_o = ready_o ? {remFix, quotFix} : 64'h0;
    end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage MIPS32 pipeline.
// Ports: clk, rst (async active-low), bus (ex_stage_if.slave: ID/EX bundle
// in, EX/MEM write bundle and stallreq_o out), hi_i/lo_i architectural HI/LO,
// mem_*/wb_* HI/LO forwards from MEM and WB.
// Everything is combinational except the divider, which stalls the pipe.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    ex_stage_if.slave   bus,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    input  logic        mem_whilo_i,
    input  logic [31:0] mem_hi_i,
    input  logic [31:0] mem_lo_i,
    input  logic        wb_whilo_i,
    input  logic [31:0] wb_hi_i,
    input  logic [31:0] wb_lo_i
);

    logic [31:0] logicOut, shiftOut, arithOut, moveOut;
    logic [31:0] hiFwd, loFwd, sum, diff;
    logic [4:0]  shAmt;
    logic        overflow, divStart, divSigned, divReady;
    hiLo_t       divResult;

    assign shAmt     = bus.reg1_i[4:0];
    assign sum       = bus.reg1_i + bus.reg2_i;
    assign diff      = bus.reg1_i - bus.reg2_i;
    assign divStart  = isDivOp(bus.aluop_i) && !divReady;
    assign divSigned = (bus.aluop_i == EXE_DIV_OP);

    ex_div u_div (
        .clk       (clk),
        .rst       (rst),
        .start_i   (divStart),
        .signed_i  (divSigned),
        .opdata1_i (bus.reg1_i),
        .opdata2_i (bus.reg2_i),
        .result_o  (divResult),
        .ready_o   (divReady)
    );

    // Newest HI/LO value wins: MEM, then WB, then the architectural copy.
    always_comb begin
        if (mem_whilo_i) begin
            hiFwd = mem_hi_i;
            loFwd = mem_lo_i;
        end else if (wb_whilo_i) begin
            hiFwd = wb_hi_i;
            loFwd = wb_lo_i;
        end else begin
            hiFwd = hi_i;
            loFwd = lo_i;
        end
    end

    // Per-class results
    always_comb begin
        logicOut = Zero_Word;
        shiftOut = Zero_Word;
        arithOut = Zero_Word;
        moveOut  = Zero_Word;
        overflow = 1'b0;
        case (bus.aluop_i)
            EXE_AND_OP:  logicOut = bus.reg1_i & bus.reg2_i;
            EXE_OR_OP:   logicOut = bus.reg1_i | bus.reg2_i;
            EXE_XOR_OP:  logicOut = bus.reg1_i ^ bus.reg2_i;
            EXE_NOR_OP:  logicOut = ~(bus.reg1_i | bus.reg2_i);
            EXE_SLL_OP:  shiftOut = bus.reg2_i << shAmt;
            EXE_SRL_OP:  shiftOut = bus.reg2_i >> shAmt;
            EXE_SRA_OP:  shiftOut = $unsigned($signed(bus.reg2_i) >>> shAmt);
            EXE_ADD_OP: begin
                arithOut = sum;
                overflow = (bus.reg1_i[31] == bus.reg2_i[31]) && (sum[31] != bus.reg1_i[31]);
            end
            EXE_SUB_OP: begin
                arithOut = diff;
                overflow = (bus.reg1_i[31] != bus.reg2_i[31]) && (diff[31] != bus.reg1_i[31]);
            end
            EXE_ADDU_OP: arithOut = sum;
            EXE_SUBU_OP: arithOut = diff;
            EXE_SLT_OP:  arithOut = {31'h0, $signed(bus.reg1_i) < $signed(bus.reg2_i)};
            EXE_SLTU_OP: arithOut = {31'h0, bus.reg1_i < bus.reg2_i};
            EXE_MFHI_OP: moveOut  = hiFwd;
            EXE_MFLO_OP: moveOut  = loFwd;
            default: ;
        endcase
    end

    // Output bundle; held at zero while reset is asserted.
    always_comb begin
        bus.wd_o              = '0;
        bus.wreg_o            = Write_Disable;
        bus.wdata_o           = Zero_Word;
        bus.whilo_o           = Write_Disable;
        bus.hi_o              = Zero_Word;
        bus.lo_o              = Zero_Word;
        bus.stallreq_o        = NoStop;
        bus.aluop_o           = EXE_NOP_OP;
        bus.is_in_delayslot_o = 1'b0;
        bus.inst_o            = Zero_Word;
        if (rst) begin
            bus.wd_o              = bus.wd_i;
            bus.wreg_o            = overflow ? Write_Disable : bus.wreg_i;
            bus.stallreq_o        = divStart ? Stop : NoStop;
            bus.aluop_o           = bus.aluop_i;
            bus.is_in_delayslot_o = bus.is_in_delayslot_i;
            bus.inst_o            = bus.inst_i;
            case (bus.alusel_i)
                EXE_RES_LOGIC:       bus.wdata_o = logicOut;
                EXE_RES_SHIFT:       bus.wdata_o = shiftOut;
                EXE_RES_ARITHMETIC:  bus.wdata_o = arithOut;
                EXE_RES_MOVE:        bus.wdata_o = moveOut;
                EXE_RES_JUMP_BRANCH: bus.wdata_o = bus.link_addr_i;
                default:             bus.wdata_o = Zero_Word;
            endcase
            if (isDivOp(bus.aluop_i)) begin
                if (divReady) begin
                    bus.whilo_o = Write_Enable;
                    bus.hi_o    = divResult.hi;
                    bus.lo_o    = divResult.lo;
                end
            end else if (bus.aluop_i == EXE_MTHI_OP) begin
                bus.whilo_o = Write_Enable;
                bus.hi_o    = bus.reg1_i;
                bus.lo_o    = loFwd;
            end else if (bus.aluop_i == EXE_MTLO_OP) begin
                bus.whilo_o = Write_Enable;
                bus.hi_o    = hiFwd;
                bus.lo_o    = bus.reg1_i;
            end
        end
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS32 pipeline. Sits directly downstream of the ID/EX pipeline register and consumes its alusel/aluop/operand/destination bundle.
- Computes logic, shift, arithmetic, compare, link and HI/LO-move results. Produces the register-write bundle for the EX/MEM register.
- Runs DIV/DIVU on an iterative divider and raises stallreq_o to ctrl until the quotient and remainder are ready.

Parameters:
- DIV_CYCLES, 32, radix-2 iterations per divide; fixed to the data width.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-low reset
- alusel_i  in  `Alu_Sel  result class from ID/EX
- aluop_i  in  `Alu_Op  operation code from ID/EX
- reg1_i, reg2_i  in  32 each  source operands
- wd_i  in  `Reg_Addr  destination register
- wreg_i  in  1  write enable
- link_addr_i  in  32  return address for JAL/JALR/BAL class
- is_in_delayslot_i  in  1  delay-slot flag, passed through
- inst_i  in  32  instruction word, passed through
- hi_i, lo_i  in  32 each  architectural HI/LO
- mem_whilo_i, mem_hi_i, mem_lo_i  in  1/32/32  HI/LO forward from MEM
- wb_whilo_i, wb_hi_i, wb_lo_i  in  1/32/32  HI/LO forward from WB
- wd_o  out  `Reg_Addr  destination
- wreg_o  out  1  write enable
- wdata_o  out  32  result
- whilo_o  out  1  HI/LO write enable
- hi_o, lo_o  out  32 each  HI/LO write data
- stallreq_o  out  1  stall request to ctrl
- aluop_o  out  `Alu_Op  passed through
- is_in_delayslot_o  out  1  passed through
- inst_o  out  32  passed through

Behaviour:
- Data path is combinational from the inputs except the divider sub-block. Outputs follow the inputs in the same cycle.
- While rst=0, every output is 0 and the divider is IDLE.
- Logic ops: AND, OR, XOR, NOR on reg1/reg2. LUI is handled as OR with the pre-shifted immediate.
- Shift ops: SLL, SRL, SRA with shift amount = reg1_i[4:0] and value = reg2_i. SRA sign-fills.
- Arithmetic: ADD, ADDU, SUB, SUBU are 32-bit wrap. SLT is a signed compare and SLTU an unsigned compare; both give 0/1.
- Overflow: ADD/SUB signed overflow forces wreg_o=0, with wd_o still driven. ADDU/SUBU never suppress the write.
- MFHI/MFLO: HI/LO value is taken with priority MEM forward > WB forward > hi_i/lo_i.
- MTHI/MTLO: whilo_o=1. The written half is reg1_i; the other half keeps its forwarded value.
- Jump/branch class: wdata_o = link_addr_i.
- Unknown alusel: wdata_o = 0.
- Divider FSM states: IDLE, BYZERO, ON, END.
  - IDLE→BYZERO when start and divisor==0.
  - IDLE→ON when start and divisor!=0.
  - BYZERO→END after 1 cycle with result 0.
  - ON stays for DIV_CYCLES cycles using restoring shift-subtract, then goes to END.
  - END asserts ready and returns to IDLE when start=0.
- Divider start = (aluop is DIV or DIVU) && !ready.
- Signed divide: operate on absolute values. Quotient is negated if the operand signs differ; remainder takes the sign of the dividend.
- Divider result: {HI,LO} = {remainder, quotient}. whilo_o=1 only while ready=1.
- stallreq_o = start. It is 1 from the cycle the DIV enters EX until the cycle before END.
- Total EX occupancy: 34 cycles for a nonzero divisor, 3 cycles for a zero divisor.
- Back-to-back DIVs: start drops in END, the FSM goes to IDLE, and the next DIV starts from IDLE the following cycle.
- Async reset mid-divide: the FSM returns to IDLE immediately and the partial result is discarded.
- Divider inputs are latched at IDLE→ON. Operand changes during ON are ignored.

Decomposition:
- Shared package: the existing define.v, which holds aluop/alusel codes, Zero_Word, Write_Enable/Disable and Stop/NoStop. Add divider state encodings DivFree, DivByZero, DivOn, DivEnd there.
- One sub-module, ex_div: the FSM, 65-bit shift register and 6-bit counter, with ports start/signed/opdata1/opdata2/result/ready.
- Everything else stays in ex_stage.

Test Plan:
- ADD 0x7FFFFFFF + 1, wreg_i=1 → wdata_o=0x80000000 and wreg_o=0. The same operands with ADDU → wreg_o=1.
- SRA reg2=0x80000000, reg1[4:0]=4 → 0xF8000000. SLT 0xFFFFFFFF vs 1 → 1. SLTU with the same operands → 0.
- MFHI with hi_i=0x11, wb forward 0x22, mem forward 0x33 all asserted → 0x33. With the mem forward deasserted → 0x22.
- DIV −7 / 2 → stallreq_o high 33 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFD and whilo_o=1 for one cycle. DIVU 100/7 → HI=2, LO=14.
- DIVU x/0 → result 0 after 2 stalled cycles. Two consecutive DIVs produce two correct results.
- Assert rst low midway through a DIV → FSM returns to IDLE, stallreq_o=0 and all outputs are 0. A DIV issued after reset completes normally.
